// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: counter encodings, table geometry
// helpers and the per-entry record.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  localparam cnt_e CNT_RST      = WNT;
  localparam int   IDX_BITS_DEF = 6;
  // Widest possible tag (IDX_BITS = 0); narrower tags are zero-extended.
  localparam int   TAG_W_MAX    = 30;

  typedef logic [TAG_W_MAX-1:0] tag_t;

  typedef struct packed {
    logic        valid;
    tag_t        tag;
    logic [31:0] tgt;
    cnt_e        cnt;
  } entry_t;

  function automatic int tag_w(input int idx_bits);
    return 32 - idx_bits - 2;
  endfunction

endpackage

// File: rtl/bp_sat_cnt.sv
// 2-bit saturating counter next-state; a fresh allocation starts weakly taken.
module bp_sat_cnt
  import bp_pkg::*;
(
  input  cnt_e cur_cnt,
  input  logic taken,
  input  logic alloc,
  output cnt_e nxt_cnt
);

  always_comb begin
    nxt_cnt = cur_cnt;
    if (alloc) begin
      nxt_cnt = WT;
    end else if (taken) begin
      if (cur_cnt != ST) nxt_cnt = cnt_e'(cur_cnt + 2'd1);
    end else begin
      if (cur_cnt != SNT) nxt_cnt = cnt_e'(cur_cnt - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter predictor with tagged BTB: combinational lookup
// for fetch, one-cycle training from EX, hit and misprediction statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_fetch_bp_i,
  output logic             brn_pred_fetch_bp_o,
  output logic [31:0]      brn_tgt_fetch_bp_o,
  output logic             btb_hit_fetch_bp_o,
  input  logic             upd_vld_ex_bp_i,
  input  logic [31:0]      upd_pc_ex_bp_i,
  input  logic             upd_taken_ex_bp_i,
  input  logic [31:0]      upd_tgt_ex_bp_i,
  input  logic             upd_pred_ex_bp_i,
  input  logic [31:0]      upd_ptgt_ex_bp_i,
  output logic [CNT_W-1:0] lookup_cnt_bp_o,
  output logic [CNT_W-1:0] mispred_cnt_bp_o
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = tag_w(IDX_BITS);

  entry_t bp_tbl [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, u_idx;
  tag_t                f_tag, u_tag;
  entry_t              f_ent;
  logic                u_hit, mispred;
  cnt_e                u_nxt;
  logic [CNT_W-1:0]    lookup_cnt_q, mispred_cnt_q;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^{pc_fetch_bp_i[1:0], upd_pc_ex_bp_i[1:0]};

  assign f_idx = pc_fetch_bp_i[IDX_BITS+1:2];
  assign f_tag = tag_t'(pc_fetch_bp_i[31:IDX_BITS+2]);
  assign u_idx = upd_pc_ex_bp_i[IDX_BITS+1:2];
  assign u_tag = tag_t'(upd_pc_ex_bp_i[31:IDX_BITS+2]);

  // Lookup reads the registered table only, so a same-cycle update is not seen.
  assign f_ent               = bp_tbl[f_idx];
  assign btb_hit_fetch_bp_o  = f_ent.valid && (f_ent.tag == f_tag);
  assign brn_pred_fetch_bp_o = btb_hit_fetch_bp_o && f_ent.cnt[1];
  assign brn_tgt_fetch_bp_o  = btb_hit_fetch_bp_o ? f_ent.tgt : 32'h0;

  assign u_hit   = bp_tbl[u_idx].valid && (bp_tbl[u_idx].tag == u_tag);
  assign mispred = (upd_taken_ex_bp_i != upd_pred_ex_bp_i) ||
                   (upd_taken_ex_bp_i && upd_pred_ex_bp_i &&
                    (upd_ptgt_ex_bp_i != upd_tgt_ex_bp_i));

  bp_sat_cnt u_sat_cnt (
    .cur_cnt (bp_tbl[u_idx].cnt),
    .taken   (upd_taken_ex_bp_i),
    .alloc   (!u_hit),
    .nxt_cnt (u_nxt)
  );

  // upd_vld_ex_bp_i is a single-cycle strobe with no back-pressure: every
  // asserted cycle is consumed at the next rising edge; upd_* are don't-care otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bp_tbl[i] <= '{valid: 1'b0, tag: '0, tgt: '0, cnt: CNT_RST};
      end
      lookup_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (btb_hit_fetch_bp_o && (lookup_cnt_q != {CNT_W{1'b1}})) begin
        lookup_cnt_q <= lookup_cnt_q + 1'b1;
      end
      if (upd_vld_ex_bp_i) begin
        if (upd_taken_ex_bp_i) begin
          bp_tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, tgt: upd_tgt_ex_bp_i, cnt: u_nxt};
        end else if (u_hit) begin
          bp_tbl[u_idx].cnt <= u_nxt;
        end
        if (mispred && (mispred_cnt_q != {CNT_W{1'b1}})) begin
          mispred_cnt_q <= mispred_cnt_q + 1'b1;
        end
      end
    end
  end

  assign lookup_cnt_bp_o  = lookup_cnt_q;
  assign mispred_cnt_bp_o = mispred_cnt_q;

  // Tag width for this geometry must fit the stored tag field.
  if (TAG_W > TAG_W_MAX) begin : g_bad_geometry
    $error("IDX_BITS too small for tag field");
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed scoreboard bench for branch_predictor against a
// table-of-integers reference model.
module tb_branch_predictor;

  localparam int IDX_BITS = 6;
  localparam int CNT_W    = 16;
  localparam int ENTRIES  = 64;
  localparam int CNT_SAT  = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_fetch = 32'h0;
  logic        pred_o, hit_o;
  logic [31:0] tgt_o;
  logic        upd_vld = 1'b0, upd_taken = 1'b0, upd_pred = 1'b0;
  logic [31:0] upd_pc = 32'h0, upd_tgt = 32'h0, upd_ptgt = 32'h0;
  logic [CNT_W-1:0] lookup_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(IDX_BITS), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pc_fetch_bp_i       (pc_fetch),
    .brn_pred_fetch_bp_o (pred_o),
    .brn_tgt_fetch_bp_o  (tgt_o),
    .btb_hit_fetch_bp_o  (hit_o),
    .upd_vld_ex_bp_i     (upd_vld),
    .upd_pc_ex_bp_i      (upd_pc),
    .upd_taken_ex_bp_i   (upd_taken),
    .upd_tgt_ex_bp_i     (upd_tgt),
    .upd_pred_ex_bp_i    (upd_pred),
    .upd_ptgt_ex_bp_i    (upd_ptgt),
    .lookup_cnt_bp_o     (lookup_cnt),
    .mispred_cnt_bp_o    (mispred_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected lookup: {hit, pred, tgt[31:0], lookup_cnt[15:0], mispred_cnt[15:0]}
  logic [65:0] exp_q[$];

  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_lk, m_mp;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 1;
    end
    m_lk = 0;
    m_mp = 0;
  endfunction

  function automatic logic [15:0] sat16(input int v);
    return (v > CNT_SAT) ? 16'hFFFF : 16'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // One fetch cycle with an optional EX update; expected lookup comes from the
  // model state before this cycle's training is applied.
  task automatic do_cycle(input logic [31:0] pc, input logic vld, input logic [31:0] upc,
                          input logic tk, input logic [31:0] tg, input logic pr,
                          input logic [31:0] ptg);
    int i, ui;
    bit hit, uhit, ep;
    @(posedge clk);
    #1;
    pc_fetch  = pc;
    upd_vld   = vld;
    upd_pc    = upc;
    upd_taken = tk;
    upd_tgt   = tg;
    upd_pred  = pr;
    upd_ptgt  = ptg;
    i   = int'((pc >> 2) % ENTRIES);
    hit = m_valid[i] && (m_tag[i] == (pc >> 8));
    ep  = hit && (m_ctr[i] >= 2);
    exp_q.push_back({hit, ep, (hit ? m_tgt[i] : 32'h0), sat16(m_lk), sat16(m_mp)});
    if (hit) m_lk++;
    if (vld) begin
      ui   = int'((upc >> 2) % ENTRIES);
      uhit = m_valid[ui] && (m_tag[ui] == (upc >> 8));
      if ((tk != pr) || (tk && pr && (ptg != tg))) m_mp++;
      if (tk) begin
        m_ctr[ui]   = uhit ? ((m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3) : 2;
        m_valid[ui] = 1'b1;
        m_tag[ui]   = upc >> 8;
        m_tgt[ui]   = tg;
      end else if (uhit && (m_ctr[ui] > 0)) begin
        m_ctr[ui] = m_ctr[ui] - 1;
      end
    end
  endtask

  task automatic look(input logic [31:0] pc);
    do_cycle(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " hit"}, {31'h0, hit_o}, 32'h0);
    check({tag, " pred"}, {31'h0, pred_o}, 32'h0);
    check({tag, " tgt"}, tgt_o, 32'h0);
    check({tag, " lookup_cnt"}, {16'h0, lookup_cnt}, 32'h0);
    check({tag, " mispred_cnt"}, {16'h0, mispred_cnt}, 32'h0);
  endtask

  // Monitor: the lookup port is valid every driven cycle; compare mid-cycle.
  initial begin
    logic [65:0] e, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {hit_o, pred_o, tgt_o, lookup_cnt, mispred_cnt};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL lookup pc=%h: got hit=%0d pred=%0d tgt=%h lk=%0d mp=%0d, expected hit=%0d pred=%0d tgt=%h lk=%0d mp=%0d",
                   pc_fetch, got[65], got[64], got[63:32], got[31:16], got[15:0],
                   e[65], e[64], e[63:32], e[31:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    logic [31:0] rpc, rupc, rtg;
    logic        rtk, rpr;
    model_reset();
    pc_fetch = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Allocation, training up, training down
    look(32'h40);
    do_cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    look(32'h40);
    do_cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    do_cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    look(32'h40);
    do_cycle(32'h40, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    look(32'h40);
    do_cycle(32'h40, 1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    look(32'h40);
    // Aliasing at index 0x10
    look(32'h140);
    do_cycle(32'h140, 1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h0);
    look(32'h40);
    look(32'h140);
    // Not-taken on a miss leaves the entry alone
    do_cycle(32'h140, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    look(32'h140);

    repeat (2000) begin
      rpc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      rupc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      rtg  = $urandom_range(0, 3) << 4;
      rtk  = 1'($urandom_range(0, 1));
      rpr  = 1'($urandom_range(0, 1));
      do_cycle(rpc, 1'($urandom_range(0, 3) != 0), rupc, rtk, rtg, rpr,
               ($urandom_range(0, 1) != 0) ? rtg : (rtg ^ 32'h10));
    end

    // Saturate both statistic counters
    repeat (CNT_SAT + 4) do_cycle(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
    look(32'h80);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #2;
    upd_vld  = 1'b0;
    pc_fetch = 32'h80;
    rst_n    = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    look(32'h80);
    look(32'h40);
    look(32'h140);
    do_cycle(32'h80, 1'b1, 32'h80, 1'b1, 32'h180, 1'b0, 32'h0);
    look(32'h80);

    repeat (10) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected lookups never compared, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
